mem_lsu: RTL
============

# mem_lsu

Memory-access stage of the bittyCore pipeline. Sits between the EX/MEM register and the MEM/WB register: consumes the ALU result, aluop, effective address and store data produced by the execute stage. For load/store aluops it runs a req/gnt/rvalid data-bus transaction, aligns and extends load data, and stalls the pipeline until done. Non-memory results pass through to writeback unchanged.

## Interface
- No parameters; widths come from `bitty_defs.v` (`RegBus`, `RegAddrBus`, `AluOpBus`, `DataAddrBus`).
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- wd_i  in  `RegAddrBus`  destination register from EX/MEM
- wreg_i  in  1  write-enable from EX/MEM
- wdata_i  in  `RegBus`  ALU/branch result from EX/MEM
- aluop_i  in  `AluOpBus`  operation; LB/LH/LW/LBU/LHU/SB/SH/SW are memory ops
- mem_addr_i  in  `DataAddrBus`  effective byte address
- reg2_i  in  `RegBus`  store data
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = store
- mem_addr_o  out  32  word address, bits [1:0] = 0
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-aligned store data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  load data valid
- mem_rdata_i  in  32  load word
- stall_req_o  out  1  hold IF..EX/MEM this cycle
- wd_o / wreg_o / wdata_o  out  registered to MEM/WB; reset 0 / 0 / `ZeroWord`
- misalign_o  out  1  registered misaligned-access pulse; reset 0
- misalign_addr_o  out  32  faulting address; reset `ZeroWord`

## Operation
- FSM: IDLE, WAIT_GNT, WAIT_RSP. Reset -> IDLE.
- IDLE, non-memory aluop: no request; next edge registers wd_i/wreg_i/wdata_i into outputs.
- IDLE/WAIT_GNT, memory aluop: mem_req_o=1 combinationally; addr/be/we/wdata held stable until gnt.
- On gnt: store -> complete, back to IDLE; load -> WAIT_RSP (request drops).
- WAIT_RSP: on rvalid, register aligned load data into wdata_o with wreg_o=wreg_i; -> IDLE.
- No gnt in IDLE -> WAIT_GNT. rvalid outside WAIT_RSP ignored.
- stall_req_o = memory op in progress and not completing this cycle (store gnt or load rvalid completes it).
- While stalling, outputs register a bubble (wreg_o=0).
- Store lanes:
  - SB: byte replicated to all lanes, be = 4'b0001 << addr[1:0].
  - SH: half replicated, be = 4'b0011 << {addr[1],1'b0}.
  - SW: be = 4'b1111.
- Load: select byte by addr[1:0], half by addr[1]. LB/LH sign-extend, LBU/LHU zero-extend. Address low bits held in a register across WAIT_RSP.
- Stores never write a register: wreg_o=0 on completion.

## Timing
- Non-memory op: 1-cycle latency, no stall.
- Store with gnt in the issue cycle: 1 cycle, no stall. Each cycle without gnt adds one stall cycle.
- Load: minimum 2 cycles (gnt in the issue cycle, rvalid the next), i.e. one stall cycle; bus wait states add cycles.
- Reset asserted mid-transaction: FSM -> IDLE and mem_req_o=0 immediately; outputs cleared; any outstanding rvalid after reset is ignored.

## Configuration
- `MEM_MISALIGN_CHK_EN` defined:
  - Misaligned accesses are LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - No bus request and no stall.
  - Next edge: misalign_o=1 for one cycle, misalign_addr_o = address, wreg_o=0.
- Undefined:
  - Misalignment is ignored; half/word accesses force the offending low address bits to 0.
  - misalign_o and misalign_addr_o are tied to 0.

## Structure
- Memory aluop codes and new state encodings (`LSU_IDLE`, `LSU_WAIT_GNT`, `LSU_WAIT_RSP`) live in `bitty_defs.v`.
- Sub-module `mem_align` (combinational) holds store lane/byte-enable generation and load extraction/extension; the FSM and registers stay in `mem_lsu`.

## Test plan
- ADD result 0x0000_1234, wd=5, wreg=1 -> next cycle wd_o=5, wreg_o=1, wdata_o=0x1234; stall_req_o never 1.
- SB reg2=0xAABB_CCDD, addr=0x103, gnt same cycle -> mem_addr_o=0x100, be=4'b1000, wdata=0xDDDD_DDDD, no stall, wreg_o=0.
- LB addr=0x202, gnt held low 2 cycles, rvalid 1 cycle after gnt, rdata=0x0080_0000 -> 3 stall cycles, then wdata_o=0xFFFF_FF80.
- LHU addr=0x302, rdata=0x8001_0000 -> wdata_o=0x0000_8001. LH on the same data -> 0xFFFF_8001.
- LW addr=0x401 with `MEM_MISALIGN_CHK_EN` -> mem_req_o stays 0, misalign_o pulses 1 cycle, misalign_addr_o=0x401. Without the macro -> bus access at 0x400.
- rst driven low while in WAIT_RSP -> mem_req_o=0, state IDLE, outputs 0; a late rvalid after reset release does not write.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared widths, aluop codes, FSM states and bus payload for the bittyCore memory stage.
package mem_lsu_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 8;
  localparam int unsigned DADDR_W    = 32;
  localparam int unsigned BE_W       = 4;

  localparam logic [ALUOP_W-1:0] OP_NOP = 8'h00;
  localparam logic [ALUOP_W-1:0] OP_ADD = 8'h20;
  localparam logic [ALUOP_W-1:0] OP_LB  = 8'h80;
  localparam logic [ALUOP_W-1:0] OP_LH  = 8'h81;
  localparam logic [ALUOP_W-1:0] OP_LW  = 8'h82;
  localparam logic [ALUOP_W-1:0] OP_LBU = 8'h84;
  localparam logic [ALUOP_W-1:0] OP_LHU = 8'h85;
  localparam logic [ALUOP_W-1:0] OP_SB  = 8'h88;
  localparam logic [ALUOP_W-1:0] OP_SH  = 8'h89;
  localparam logic [ALUOP_W-1:0] OP_SW  = 8'h8B;

  typedef enum logic [1:0] {
    LSU_IDLE     = 2'd0,
    LSU_WAIT_GNT = 2'd1,
    LSU_WAIT_RSP = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic               we;
    logic [DADDR_W-1:0] addr;
    logic [BE_W-1:0]    be;
    logic [REG_W-1:0]   wdata;
  } lsu_bus_t;

  function automatic logic is_load(input logic [ALUOP_W-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [ALUOP_W-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_half(input logic [ALUOP_W-1:0] op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction

  function automatic logic is_word(input logic [ALUOP_W-1:0] op);
    return op inside {OP_LW, OP_SW};
  endfunction

  function automatic logic misaligned(input logic [ALUOP_W-1:0] op,
                                      input logic [DADDR_W-1:0] addr);
    return (is_half(op) && addr[0]) || (is_word(op) && (addr[1:0] != 2'b00));
  endfunction

  // Drop the low address bits that a half/word access cannot honour.
  function automatic logic [DADDR_W-1:0] force_align(input logic [ALUOP_W-1:0] op,
                                                     input logic [DADDR_W-1:0] addr);
    if (is_word(op)) return {addr[DADDR_W-1:2], 2'b00};
    if (is_half(op)) return {addr[DADDR_W-1:1], 1'b0};
    return addr;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane steering: store replication/byte enables and load extraction/extension.
module mem_align
  import mem_lsu_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [DADDR_W-1:0] addr,
  input  logic [REG_W-1:0]   st_data,
  input  logic [ALUOP_W-1:0] ld_op,
  input  logic [1:0]         ld_off,
  input  logic [REG_W-1:0]   rdata,
  output lsu_bus_t           bus_c,
  output logic [REG_W-1:0]   ld_data_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    bus_c       = '0;
    bus_c.we    = is_store(aluop);
    bus_c.addr  = {addr[DADDR_W-1:2], 2'b00};
    bus_c.be    = 4'b1111;
    bus_c.wdata = st_data;
    if (aluop inside {OP_LB, OP_LBU, OP_SB}) begin
      bus_c.be    = 4'b0001 << addr[1:0];
      bus_c.wdata = {4{st_data[7:0]}};
    end else if (is_half(aluop)) begin
      bus_c.be    = 4'b0011 << {addr[1], 1'b0};
      bus_c.wdata = {2{st_data[15:0]}};
    end
  end

  always_comb begin
    ld_byte   = rdata[8*ld_off +: 8];
    ld_half   = ld_off[1] ? rdata[31:16] : rdata[15:0];
    ld_data_c = rdata;
    case (ld_op)
      OP_LB:   ld_data_c = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data_c = {24'h0, ld_byte};
      OP_LH:   ld_data_c = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data_c = {16'h0, ld_half};
      default: ld_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// bittyCore memory stage: req/gnt/rvalid bus FSM, pipeline stall and MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHK_EN.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_W-1:0]      wdata_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [DADDR_W-1:0]    mem_addr_i,
  input  logic [REG_W-1:0]      reg2_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  stall_req_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic                  misalign_o,
  output logic [31:0]           misalign_addr_o
);

  lsu_state_e            state, state_nxt;
  logic                  load_op, store_op, mem_op, bad_c, issue_c;
  logic [DADDR_W-1:0]    addr_c;
  logic [ALUOP_W-1:0]    ld_op_q;
  logic [1:0]            ld_off_q;
  lsu_bus_t              bus_c;
  logic [REG_W-1:0]      ld_data_c;
  logic [REG_ADDR_W-1:0] wd_nxt;
  logic                  wreg_nxt;
  logic [REG_W-1:0]      wdata_nxt;

  assign load_op  = is_load(aluop_i);
  assign store_op = is_store(aluop_i);
  assign mem_op   = load_op | store_op;
  assign addr_c   = force_align(aluop_i, mem_addr_i);
  // Request is gated by reset so it drops the instant reset asserts.
  assign issue_c  = rst && mem_op && !bad_c &&
                    (state == LSU_IDLE || state == LSU_WAIT_GNT);

  mem_align u_align (
    .aluop     (aluop_i),
    .addr      (addr_c),
    .st_data   (reg2_i),
    .ld_op     (ld_op_q),
    .ld_off    (ld_off_q),
    .rdata     (mem_rdata_i),
    .bus_c     (bus_c),
    .ld_data_c (ld_data_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LSU_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE, LSU_WAIT_GNT: begin
        if (!issue_c)        state_nxt = LSU_IDLE;
        else if (!mem_gnt_i) state_nxt = LSU_WAIT_GNT;
        else if (load_op)    state_nxt = LSU_WAIT_RSP;
        else                 state_nxt = LSU_IDLE;
      end
      LSU_WAIT_RSP: if (mem_rvalid_i) state_nxt = LSU_IDLE;
      default:      state_nxt = LSU_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = issue_c;
    mem_we_o    = issue_c & bus_c.we;
    mem_addr_o  = issue_c ? bus_c.addr  : '0;
    mem_be_o    = issue_c ? bus_c.be    : '0;
    mem_wdata_o = issue_c ? bus_c.wdata : '0;
    stall_req_o = (issue_c && !(store_op && mem_gnt_i)) ||
                  (state == LSU_WAIT_RSP && !mem_rvalid_i);
    // Bubble by default; covers stalls, store completion and misaligned traps.
    wd_nxt    = '0;
    wreg_nxt  = 1'b0;
    wdata_nxt = '0;
    if (state == LSU_IDLE && !mem_op) begin
      wd_nxt    = wd_i;
      wreg_nxt  = wreg_i;
      wdata_nxt = wdata_i;
    end else if (state == LSU_WAIT_RSP && mem_rvalid_i) begin
      wd_nxt    = wd_i;
      wreg_nxt  = wreg_i;
      wdata_nxt = ld_data_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_o     <= '0;
      wreg_o   <= 1'b0;
      wdata_o  <= '0;
      ld_op_q  <= OP_NOP;
      ld_off_q <= 2'b00;
    end else begin
      wd_o    <= wd_nxt;
      wreg_o  <= wreg_nxt;
      wdata_o <= wdata_nxt;
      if (issue_c && mem_gnt_i && load_op) begin
        ld_op_q  <= aluop_i;
        ld_off_q <= addr_c[1:0];
      end
    end
  end

`ifdef MEM_MISALIGN_CHK_EN
  logic mis_nxt;

  assign bad_c   = misaligned(aluop_i, mem_addr_i);
  assign mis_nxt = mem_op && bad_c && state != LSU_WAIT_RSP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      misalign_o      <= mis_nxt;
      misalign_addr_o <= mis_nxt ? mem_addr_i : 32'h0;
    end
  end
`else
  assign bad_c           = 1'b0;
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = '0;
`endif

endmodule
